mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the register file: consumes the RS/RT read data for mult, multu, div and divu, and serves HI/LO to the write-back mux for mfhi/mflo. Handles mthi/mtlo writes. The decode/control stage stalls the pipeline while `busy_o` is high.

## Interface
- No parameters; datapath width fixed at 32.
- `clk_i` input 1: clock, all state updates on rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `start_i` input 1: begin an operation using `op_i`, `rs_i`, `rt_i`.
- `op_i` input 2: operation select.
  - 00: mult (signed multiply).
  - 01: multu (unsigned multiply).
  - 10: div (signed divide).
  - 11: divu (unsigned divide).
- `rs_i` input 32: multiplicand or dividend (RSdata).
- `rt_i` input 32: multiplier or divisor (RTdata).
- `hi_we_i` input 1: mthi write enable.
- `lo_we_i` input 1: mtlo write enable.
- `wdata_i` input 32: mthi/mtlo data (RSdata).
- `busy_o` output 1: operation in progress.
- `done_o` output 1: one-cycle pulse when HI/LO hold a new result.
- `hi_o` output 32: HI register.
- `lo_o` output 32: LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - `start_i`=1: latch operands and op, clear 5-bit iteration counter, go to RUN.
  - Operands used are the values present at the start edge only; later changes on `rs_i`/`rt_i` are ignored.
- RUN: one radix-2 step per cycle for exactly 32 cycles (counter 0..31). After the counter-31 step, go to FIX.
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring divide on magnitudes; 32-bit remainder plus 32-bit quotient.
- FIX: apply sign correction, write HI/LO, go to IDLE.
  - mult: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - multu: no correction.
  - div: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - divu: no correction.
  - Divide by zero (div or divu): LO = 0xFFFFFFFF, HI = `rs_i` as latched; sign correction is skipped.
  - div of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
- Magnitude of 0x80000000 is treated as unsigned 0x80000000. All internal arithmetic is 33/64-bit; no intermediate overflow.
- mthi/mtlo:
  - In IDLE: HI (`hi_we_i`) and/or LO (`lo_we_i`) take `wdata_i` at the edge. Both enables set writes both registers.
  - In RUN/FIX: both enables are ignored.
  - If `start_i` is at the same IDLE edge: the write is applied and later overwritten by the result in FIX.
- `start_i` in RUN/FIX is ignored, with no queueing.
- `op_i` is don't-care when `start_i`=0.

## Timing
- Let E0 be the edge at which `start_i` is sampled in IDLE.
  - E1..E32: RUN iterations.
  - E33: FIX writes HI/LO and returns to IDLE.
- `busy_o` = (state != IDLE), registered. It is high from after E0 until E33: 33 cycles.
- `done_o` is high for exactly the one cycle after E33. During that cycle `busy_o`=0 and HI/LO show the new result.
- Back-to-back: `start_i` may be asserted in the `done_o` cycle. It is accepted at that edge (E34), giving the next `done_o` at E34+33.
- `hi_o`/`lo_o` are register outputs.
  - They hold the previous values throughout RUN/FIX.
  - They change only at E33 or on an mthi/mtlo edge.
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `hi_o`=0, `lo_o`=0, counter 0.
- Reset asserted mid-operation: immediate return to reset values. The partial result is discarded and no `done_o` pulse is produced.

## Test plan
- mult rs=7, rt=0xFFFFFFFD (−3): `busy_o` high 33 cycles, then `done_o` for one cycle. Result HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu rs=rt=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. Follow with an mult started in the `done_o` cycle; it must be accepted, with the next `done_o` 33 cycles later.
- div rs=0xFFFFFFF9 (−7), rt=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu rs=100, rt=7: LO=14, HI=2.
- div rs=0x80000000, rt=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu rs=0x12345678, rt=0: LO=0xFFFFFFFF, HI=0x12345678.
- mthi/mtlo and reset:
  - Setup: mthi 0xAAAA0000 and mtlo 0x5555 in IDLE; both values must appear on the next edge.
  - Start a mult and pulse `hi_we_i` mid-RUN: HI must stay 0xAAAA0000 until the result is written.
  - Assert `rst_i` at iteration 10 of a new operation: `busy_o`, HI and LO all 0 immediately, and no `done_o` pulse.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Each operation takes one radix-2 step per cycle for 32 cycles, then one
// sign-fix cycle that writes HI/LO. mthi/mtlo writes land only while idle.
module mul_div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 2 * W;
    localparam int unsigned CW = 5;

    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    // op_i[1] selects divide, op_i[0] selects unsigned
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  rs_q, rs_d;       // dividend as latched, needed for divide-by-zero
    logic          rt_sign_q, rt_sign_d;
    logic [W-1:0]  opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [AW-1:0] acc_q, acc_d;     // {hi/remainder, lo/quotient}
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Operand magnitudes at the start edge; 0x80000000 stays 0x80000000
    logic          start_signed;
    logic [W-1:0]  rs_mag, rt_mag;

    assign start_signed = ~op_i[0];
    assign rs_mag = (start_signed && rs_i[W-1]) ? W'(-rs_i) : rs_i;
    assign rt_mag = (start_signed && rt_i[W-1]) ? W'(-rt_i) : rt_i;

    // One shift-add multiply step: conditionally add, then shift the 65-bit sum right
    logic [W:0]    mul_sum;
    logic [AW-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // One restoring divide step: shift in next dividend bit, subtract if it fits
    logic [W:0]    div_shift;
    logic [W:0]    div_sub;
    logic          div_fit;
    logic [AW-1:0] div_next;

    assign div_shift = {acc_q[AW-1:W], acc_q[W-1]};
    assign div_sub   = div_shift - {1'b0, opnd_q};
    assign div_fit   = (div_shift >= {1'b0, opnd_q});
    assign div_next  = div_fit ? {div_sub[W-1:0],   acc_q[W-2:0], 1'b1}
                               : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};

    // Sign correction applied in FIX
    logic          op_signed;
    logic          res_neg;
    logic          rem_neg;
    logic          div_by_zero;
    logic [AW-1:0] prod_fix;
    logic [W-1:0]  quot_fix;
    logic [W-1:0]  rem_fix;

    assign op_signed   = ~op_q[0];
    assign res_neg     = op_signed && (rs_q[W-1] ^ rt_sign_q);
    assign rem_neg     = op_signed && rs_q[W-1];
    assign div_by_zero = (opnd_q == W'(0));
    assign prod_fix    = res_neg ? AW'(-acc_q) : acc_q;
    assign quot_fix    = res_neg ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
    assign rem_fix     = rem_neg ? W'(-acc_q[AW-1:W]) : acc_q[AW-1:W];

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rs_q      <= '0;
            rt_sign_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rs_q      <= rs_d;
            rt_sign_q <= rt_sign_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, iteration and HI/LO update logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rt_sign_d = rt_sign_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hi_we_i) begin
                    hi_d = wdata_i;
                end
                if (lo_we_i) begin
                    lo_d = wdata_i;
                end
                if (start_i) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    op_d      = op_i;
                    rs_d      = rs_i;
                    rt_sign_d = rt_i[W-1];
                    // Divide shifts the dividend through lo; multiply shifts the multiplier
                    if (op_i[1]) begin
                        opnd_d = rt_mag;
                        acc_d  = {W'(0), rs_mag};
                    end else begin
                        opnd_d = rs_mag;
                        acc_d  = {W'(0), rt_mag};
                    end
                end
            end
            ST_RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = CW'(cnt_q + CW'(1));
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!op_q[1]) begin
                    hi_d = prod_fix[AW-1:W];
                    lo_d = prod_fix[W-1:0];
                end else if (div_by_zero) begin
                    hi_d = rs_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_FIX);
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic results, latency, back-to-back
// issue, mthi/mtlo behaviour and mid-operation reset.
module tb_mul_div_unit;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mul_div_unit dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .hi_we_i (hi_we_i),
        .lo_we_i (lo_we_i),
        .wdata_i (wdata_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation from the current cycle and leave the bench in the done cycle
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int poke);
        int  cyc;
        int  busy_low;
        int  unstable;
        bit  seen;
        start_i = 1'b1;
        op_i    = op;
        rs_i    = rs;
        rt_i    = rt;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        rs_i    = ~rs;
        rt_i    = 32'h5a5a_5a5a;
        op_i    = ~op;
        chk({tag, " busy_after_start"}, 64'(busy_o), 64'd1);
        cyc = 0; busy_low = 0; unstable = 0; seen = 0;
        while (!seen && cyc < 40) begin
            if (cyc == poke) begin
                hi_we_i = 1'b1;
                lo_we_i = 1'b1;
                wdata_i = 32'h1111_2222;
            end
            @(posedge clk_i); #1;
            hi_we_i = 1'b0;
            lo_we_i = 1'b0;
            cyc++;
            if (done_o) begin
                seen = 1;
            end else begin
                if (!busy_o) busy_low++;
                if (hi_o !== prev_hi || lo_o !== prev_lo) unstable++;
            end
        end
        chk({tag, " latency"}, 64'(cyc), 64'd33);
        chk({tag, " busy_gaps"}, 64'(busy_low), 64'd0);
        chk({tag, " hilo_hold"}, 64'(unstable), 64'd0);
        chk({tag, " busy_in_done"}, 64'(busy_o), 64'd0);
        chk({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
    endtask

    // One idle cycle after a done cycle; the pulse must be gone
    task automatic idle_cycle(input string tag);
        @(posedge clk_i); #1;
        chk({tag, " done_drop"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        int pulses;
        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        rs_i    = '0;
        rt_i    = '0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        wdata_i = '0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst done", 64'(done_o), 64'd0);
        chk("rst hi", 64'(hi_o), 64'd0);
        chk("rst lo", 64'(lo_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // mthi then mtlo while idle
        hi_we_i = 1'b1; wdata_i = 32'hAAAA_0000;
        @(posedge clk_i); #1;
        hi_we_i = 1'b0;
        chk("mthi hi", 64'(hi_o), 64'h0000_0000_AAAA_0000);
        chk("mthi lo", 64'(lo_o), 64'd0);
        lo_we_i = 1'b1; wdata_i = 32'h0000_5555;
        @(posedge clk_i); #1;
        lo_we_i = 1'b0;
        chk("mtlo lo", 64'(lo_o), 64'h5555);
        chk("mtlo hi", 64'(hi_o), 64'h0000_0000_AAAA_0000);

        // 7 * -3 = -21, with mthi/mtlo poked mid-run (must be ignored)
        do_op("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD,
              32'hAAAA_0000, 32'h0000_5555, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 10);
        idle_cycle("mult_7_m3");

        // multu max*max, then a mult accepted in the done cycle
        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        do_op("mult_b2b", OP_MULT, 32'hFFFF_0000, 32'h0001_0000,
              32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, -1);
        idle_cycle("mult_b2b");

        do_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000,
              32'hFFFF_FFFF, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, -1);
        idle_cycle("mult_minmin");

        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
              32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        idle_cycle("div_m7_2");

        do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFD, -1);
        idle_cycle("div_7_m2");

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7,
              32'h0000_0001, 32'hFFFF_FFFD, 32'd2, 32'd14, -1);
        idle_cycle("divu_100_7");

        do_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd2, 32'd14, 32'h0000_0000, 32'h8000_0000, -1);
        idle_cycle("div_min_m1");

        do_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0,
              32'h0000_0000, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, -1);
        idle_cycle("divu_by0");

        do_op("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0,
              32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
        idle_cycle("div_by0");

        // Reset during iteration 10 of a new operation
        start_i = 1'b1; op_i = OP_DIVU; rs_i = 32'd1000; rt_i = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_mid busy", 64'(busy_o), 64'd0);
        chk("rst_mid hi", 64'(hi_o), 64'd0);
        chk("rst_mid lo", 64'(lo_o), 64'd0);
        chk("rst_mid done", 64'(done_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o) pulses++;
        end
        chk("rst_mid no_done", 64'(pulses), 64'd0);

        // Unit must be usable again after the abort
        do_op("multu_after_rst", OP_MULTU, 32'd6, 32'd7,
              32'd0, 32'd0, 32'd0, 32'd42, -1);
        idle_cycle("multu_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
